// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with 2-bit direction counters and branch statistics
// Ports:
//   clk, reset (async, active-low)
//   lookup_pc -> pred_taken, pred_target          combinational IF-stage prediction
//   upd_valid, upd_pc, upd_taken, upd_target,
//   upd_pred_taken, upd_pred_target               branch resolved in EX
//   mispredict, redirect_pc                       combinational flush/redirect
//   stat_branches, stat_mispredicts               saturating registered counters
module branch_predictor_btb #(
   parameter int ADDR_WIDTH = 32,
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = 8,
   parameter int STAT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   output logic                  pred_taken,
   output logic [ADDR_WIDTH-1:0] pred_target,
   input  logic                  upd_valid,
   input  logic [ADDR_WIDTH-1:0] upd_pc,
   input  logic                  upd_taken,
   input  logic [ADDR_WIDTH-1:0] upd_target,
   input  logic                  upd_pred_taken,
   input  logic [ADDR_WIDTH-1:0] upd_pred_target,
   output logic                  mispredict,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [STAT_WIDTH-1:0] stat_branches,
   output logic [STAT_WIDTH-1:0] stat_mispredicts
);
   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [ENTRIES-1:0]    valid_q;
   logic [TAG_BITS-1:0]   tags   [ENTRIES];
   logic [ADDR_WIDTH-1:0] targets[ENTRIES];
   logic [1:0]            ctrs   [ENTRIES];

   logic [INDEX_BITS-1:0] l_idx, u_idx;
   logic [TAG_BITS-1:0]   l_tag, u_tag;
   logic                  l_hit, u_hit;
   logic [1:0]            ctr_next;

   assign l_idx = lookup_pc[INDEX_BITS+1:2];
   assign l_tag = lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign u_idx = upd_pc[INDEX_BITS+1:2];
   assign u_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

   // Lookup reads the registered table only, so a same-cycle update is not bypassed
   assign l_hit       = valid_q[l_idx] && (tags[l_idx] == l_tag);
   assign pred_taken  = l_hit && ctrs[l_idx][1];
   assign pred_target = pred_taken ? targets[l_idx] : lookup_pc + ADDR_WIDTH'(4);

   // Gated by reset so no flush is requested while the table is being cleared
   assign mispredict  = reset && upd_valid &&
                        ((upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target)));
   assign redirect_pc = (mispredict && upd_taken) ? upd_target : upd_pc + ADDR_WIDTH'(4);

   assign u_hit    = valid_q[u_idx] && (tags[u_idx] == u_tag);
   assign ctr_next = upd_taken ? ((ctrs[u_idx] == 2'b11) ? 2'b11 : ctrs[u_idx] + 2'd1)
                               : ((ctrs[u_idx] == 2'b00) ? 2'b00 : ctrs[u_idx] - 2'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q          <= '0;
         stat_branches    <= '0;
         stat_mispredicts <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tags[i]    <= '0;
            targets[i] <= '0;
            ctrs[i]    <= 2'b01;
         end
      end else if (upd_valid) begin
         if (u_hit) begin
            ctrs[u_idx] <= ctr_next;
            if (upd_taken) targets[u_idx] <= upd_target;
         end else if (upd_taken) begin
            valid_q[u_idx] <= 1'b1;
            tags[u_idx]    <= u_tag;
            targets[u_idx] <= upd_target;
            ctrs[u_idx]    <= 2'b10;
         end
         if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
         if (mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed self-checking bench for branch_predictor_btb
module tb_branch_predictor_btb;
   localparam int AW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] lookup_pc = '0;
   logic          pred_taken;
   logic [AW-1:0] pred_target;
   logic          upd_valid = 1'b0;
   logic [AW-1:0] upd_pc = '0;
   logic          upd_taken = 1'b0;
   logic [AW-1:0] upd_target = '0;
   logic          upd_pred_taken = 1'b0;
   logic [AW-1:0] upd_pred_target = '0;
   logic          mispredict;
   logic [AW-1:0] redirect_pc;
   logic [SW-1:0] stat_branches;
   logic [SW-1:0] stat_mispredicts;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   branch_predictor_btb #(.ADDR_WIDTH(AW), .INDEX_BITS(4), .TAG_BITS(8), .STAT_WIDTH(SW)) dut (
      .clk(clk), .reset(reset),
      .lookup_pc(lookup_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tg,
                      input logic pt, input logic [AW-1:0] ptt);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tg;
      upd_pred_taken = pt; upd_pred_target = ptt;
      #1;
   endtask

   task automatic idle();
      upd_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      upd(32'h0040_0020, 1'b1, 32'h0040_0000, 1'b0, 32'h0);
      vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL reset_mispredict got %0b exp 0", mispredict); end
      tick(); tick();
      idle();
      reset = 1'b1;
      lookup_pc = 32'h0040_0010;
      #1;
      vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_pred_taken got %0b exp 0", pred_taken); end
      vectors++; if (pred_target !== 32'h0040_0014) begin miscompares++; $display("FAIL reset_pred_target got %h exp 00400014", pred_target); end
      vectors++; if (stat_branches !== 4'h0) begin miscompares++; $display("FAIL reset_stat_branches got %h exp 0", stat_branches); end
      vectors++; if (stat_mispredicts !== 4'h0) begin miscompares++; $display("FAIL reset_stat_mispredicts got %h exp 0", stat_mispredicts); end
   endtask

   task automatic test_first_alloc();
      lookup_pc = 32'h0040_0020;
      upd(32'h0040_0020, 1'b1, 32'h0040_0000, 1'b0, 32'h0040_0024);
      vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL alloc_mispredict got %0b exp 1", mispredict); end
      vectors++; if (redirect_pc !== 32'h0040_0000) begin miscompares++; $display("FAIL alloc_redirect got %h exp 00400000", redirect_pc); end
      vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL alloc_pre_pred got %0b exp 0", pred_taken); end
      tick();
      idle();
      vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL alloc_pred_taken got %0b exp 1", pred_taken); end
      vectors++; if (pred_target !== 32'h0040_0000) begin miscompares++; $display("FAIL alloc_pred_target got %h exp 00400000", pred_target); end
      vectors++; if (stat_branches !== 4'h1) begin miscompares++; $display("FAIL alloc_stat_branches got %h exp 1", stat_branches); end
      vectors++; if (stat_mispredicts !== 4'h1) begin miscompares++; $display("FAIL alloc_stat_mispredicts got %h exp 1", stat_mispredicts); end
   endtask

   task automatic test_saturation();
      lookup_pc = 32'h0040_0020;
      for (int i = 0; i < 3; i++) begin
         upd(32'h0040_0020, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0000);
         vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL sat_taken_mispredict[%0d] got %0b exp 0", i, mispredict); end
         tick();
      end
      upd(32'h0040_0020, 1'b0, 32'h0040_0000, 1'b1, 32'h0040_0000);
      vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL sat_nt1_mispredict got %0b exp 1", mispredict); end
      vectors++; if (redirect_pc !== 32'h0040_0024) begin miscompares++; $display("FAIL sat_nt1_redirect got %h exp 00400024", redirect_pc); end
      tick();
      idle();
      vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL sat_nt1_pred got %0b exp 1", pred_taken); end
      upd(32'h0040_0020, 1'b0, 32'h0040_0000, 1'b1, 32'h0040_0000);
      vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL sat_nt2_mispredict got %0b exp 1", mispredict); end
      tick();
      idle();
      vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL sat_nt2_pred got %0b exp 0", pred_taken); end
      vectors++; if (pred_target !== 32'h0040_0024) begin miscompares++; $display("FAIL sat_nt2_target got %h exp 00400024", pred_target); end
      vectors++; if (stat_branches !== 4'h6) begin miscompares++; $display("FAIL sat_stat_branches got %h exp 6", stat_branches); end
      vectors++; if (stat_mispredicts !== 4'h3) begin miscompares++; $display("FAIL sat_stat_mispredicts got %h exp 3", stat_mispredicts); end
   endtask

   task automatic test_alias();
      lookup_pc = 32'h0040_0020;
      upd(32'h0040_0020, 1'b1, 32'h0040_0000, 1'b0, 32'h0040_0000);
      tick();
      idle();
      vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL alias_before got %0b exp 1", pred_taken); end
      upd(32'h0040_1020, 1'b1, 32'h0040_2000, 1'b0, 32'h0);
      tick();
      idle();
      vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL alias_old_pred got %0b exp 0", pred_taken); end
      lookup_pc = 32'h0040_1020;
      #1;
      vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL alias_new_pred got %0b exp 1", pred_taken); end
      vectors++; if (pred_target !== 32'h0040_2000) begin miscompares++; $display("FAIL alias_new_target got %h exp 00402000", pred_target); end
      upd(32'h0040_0060, 1'b0, 32'h0040_3000, 1'b0, 32'h0);
      vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL miss_nt_mispredict got %0b exp 0", mispredict); end
      tick();
      idle();
      vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h0040_2000) begin miscompares++; $display("FAIL miss_nt_nochange got %0b/%h exp 1/00402000", pred_taken, pred_target); end
   endtask

   task automatic test_same_cycle();
      lookup_pc = 32'h0040_0040;
      upd(32'h0040_0040, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
      vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h0040_0044) begin miscompares++; $display("FAIL same_cycle_pred got %0b/%h exp 0/00400044", pred_taken, pred_target); end
      tick();
      idle();
      vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h0040_0100) begin miscompares++; $display("FAIL same_cycle_next got %0b/%h exp 1/00400100", pred_taken, pred_target); end
      upd(32'h0040_0040, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0200);
      vectors++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0100) begin miscompares++; $display("FAIL target_mispredict got %0b/%h exp 1/00400100", mispredict, redirect_pc); end
      idle();
      lookup_pc = 32'hFFFF_FFFC;
      #1;
      vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_target got %0b/%h exp 0/00000000", pred_taken, pred_target); end
   endtask

   task automatic test_stat_saturation();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      for (int i = 0; i < 17; i++) begin
         upd(32'h0040_0080, 1'b1, 32'h0040_0000, 1'b0, 32'h0);
         tick();
      end
      vectors++; if (stat_branches !== 4'hF) begin miscompares++; $display("FAIL stat_sat_branches got %h exp f", stat_branches); end
      vectors++; if (stat_mispredicts !== 4'hF) begin miscompares++; $display("FAIL stat_sat_mispredicts got %h exp f", stat_mispredicts); end
      lookup_pc = 32'h0040_0040;
      #2;
      reset = 1'b0;
      #1;
      vectors++; if (stat_branches !== 4'h0 || stat_mispredicts !== 4'h0) begin miscompares++; $display("FAIL async_reset_stats got %h/%h exp 0/0", stat_branches, stat_mispredicts); end
      vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL async_reset_table got %0b exp 0", pred_taken); end
      tick();
      vectors++; if (stat_branches !== 4'h0) begin miscompares++; $display("FAIL reset_edge_discard got %h exp 0", stat_branches); end
      reset = 1'b1;
      idle();
      lookup_pc = 32'h0040_0080;
      #1;
      vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_edge_no_alloc got %0b exp 0", pred_taken); end
   endtask

   initial begin
      test_reset();
      test_first_alloc();
      test_saturation();
      test_alias();
      test_same_cycle();
      test_stat_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters, for the next-generation 5-stage pipeline.
- Lookup is combinational in IF and supplies predicted next PC.
- Resolved branches from EX update the table and raise a mispredict redirect, replacing the fixed predict-not-taken scheme where every taken branch flushes IF/ID and ID/EX.
- Registered statistics counters track branches and mispredicts.

Parameters:
- ADDR_WIDTH, 32, PC/target width in bits.
- INDEX_BITS, 4, log2 of entry count (16 entries, direct-mapped).
- TAG_BITS, 8, stored tag width. Constraint: INDEX_BITS+TAG_BITS+2 <= ADDR_WIDTH.
- STAT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_pc  in  ADDR_WIDTH  PC of the instruction currently in IF.
- pred_taken  out  1  predicted taken for lookup_pc.
- pred_target  out  ADDR_WIDTH  predicted next PC.
- upd_valid  in  1  a branch resolved in EX this cycle.
- upd_pc  in  ADDR_WIDTH  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_WIDTH  actual taken target (PC_Add).
- upd_pred_taken  in  1  pred_taken carried down the pipe with the branch.
- upd_pred_target  in  ADDR_WIDTH  pred_target carried down the pipe with the branch.
- mispredict  out  1  combinational flush/redirect request.
- redirect_pc  out  ADDR_WIDTH  correct next PC when mispredict=1.
- stat_branches  out  STAT_WIDTH  count of resolved branches.
- stat_mispredicts  out  STAT_WIDTH  count of mispredicts.

Behaviour:
- Address fields:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target (ADDR_WIDTH), ctr (2 bits).
- Reset (reset=0, asynchronous):
  - All valid bits = 0, all ctr = 2'b01, targets and tags = 0.
  - stat_branches = stat_mispredicts = 0.
  - Outputs during reset: pred_taken=0, pred_target=lookup_pc+4, mispredict=0.
- Lookup (combinational, zero latency):
  - hit = valid[index] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : lookup_pc+4. The +4 wraps modulo 2^ADDR_WIDTH.
- Mispredict (combinational, upd_valid=1 only; otherwise 0):
  - mispredict = (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - redirect_pc is a don't-care when mispredict=0; the implementation drives upd_pc+4.
- Table update, at the rising edge when upd_valid=1:
  - Hit (using upd_pc): ctr saturating increment if taken, decrement if not taken (limits 2'b11 and 2'b00). If taken, target <= upd_target.
  - Miss and taken: allocate (overwrite any existing entry at that index): valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss and not taken: no change.
- Statistics, at the rising edge when upd_valid=1:
  - stat_branches increments.
  - stat_mispredicts increments if mispredict.
  - Both saturate at all-ones; no wrap.
- Simultaneous lookup and update to the same index in one cycle:
  - Lookup returns the pre-update entry; there is no write-through bypass.
  - The new state is visible from the next cycle.
- Reset asserted mid-operation:
  - The table and stats clear immediately.
  - An update whose edge coincides with reset is discarded.
- Flushed instructions must arrive with upd_valid=0. The block does not check this.

Test Plan:
- Reset then lookup_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014; stats=0.
- Branch at 0x00400020 first update, taken, target 0x00400000, upd_pred_taken=0 -> mispredict=1, redirect_pc=0x00400000. Next cycle lookup 0x00400020 -> pred_taken=1, pred_target=0x00400000; stat_branches=1, stat_mispredicts=1.
- Counter saturation for the same branch:
  - 3 more taken updates -> ctr=2'b11.
  - 1 not-taken update -> ctr=2'b10, pred_taken stays 1, mispredict pulses, redirect_pc=0x00400024.
  - 2nd not-taken update -> ctr=2'b01, pred_taken=0.
- Aliasing: 0x00400020 allocated, then taken update at 0x00401020 (same index, different tag) -> entry replaced; lookup 0x00400020 -> pred_taken=0.
- Same-cycle update and lookup at index of 0x00400040 (first allocation) -> pred_taken=0 that cycle, 1 the next cycle.
- Stat saturation with STAT_WIDTH=4: 17 mispredicting updates -> stat_branches=stat_mispredicts=4'hF. Async reset pulse between clock edges -> both read 0 immediately.
